// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared pipeline definitions.
//   - Register-file geometry: XLEN, NREGS, REG_IDX_W.
//   - Common typedefs: reg_idx_t, xlen_t, busy_vec_t.
//   - Base opcode constants used by decode.
//   - A small helper that turns a register index into a one-hot mask.
package reg_file_sb_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = $clog2(NREGS);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;
  typedef logic [NREGS-1:0]     busy_vec_t;

  localparam reg_idx_t  REG_X0    = {REG_IDX_W{1'b0}};
  localparam xlen_t     XLEN_ZERO = {XLEN{1'b0}};
  localparam busy_vec_t BUSY_NONE = {NREGS{1'b0}};

  // Base integer opcodes (bits [6:0] of the instruction word)
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // One-hot mask with only bit 'idx' set
  function automatic busy_vec_t idx_mask(input reg_idx_t idx);
    busy_vec_t m;
    m      = BUSY_NONE;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-destination tracker for the integer register file.
//   clk, reset          - clock, asynchronous active-high reset
//   write_enable/_reg   - write-back landing; clears the destination's busy bit
//   issue_valid/_rd     - decode reserving a destination; sets its busy bit
//   flush               - drops every reservation (and any same-cycle one)
//   busy                - busy vector, bit 0 is never set
//   busy_count          - number of set busy bits, kept as a registered counter
// When a register is set and cleared in the same cycle the set wins: the
// newer instruction owns the register.
module reg_scoreboard
  import reg_file_sb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_enable,
  input  logic [REG_IDX_W-1:0] write_reg,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 flush,
  output logic [NREGS-1:0]     busy,
  output logic [REG_IDX_W:0]   busy_count
);

  localparam logic [REG_IDX_W:0] CNT_ZERO = {(REG_IDX_W+1){1'b0}};

  busy_vec_t              busy_r;
  busy_vec_t              busy_next_s;
  busy_vec_t              set_mask_s;
  busy_vec_t              clr_mask_s;
  logic                   set_s;
  logic                   clr_s;
  logic                   cnt_inc_s;
  logic                   cnt_dec_s;
  logic [REG_IDX_W:0]     count_r;
  logic [REG_IDX_W:0]     count_next_s;

  // Set/clear decode, set-wins merge and counter delta
  always_comb begin
    set_s        = issue_valid && (issue_rd != REG_X0) && !flush;
    clr_s        = write_enable && (write_reg != REG_X0);
    set_mask_s   = BUSY_NONE;
    clr_mask_s   = BUSY_NONE;
    busy_next_s  = busy_r;
    cnt_inc_s    = 1'b0;
    cnt_dec_s    = 1'b0;
    count_next_s = count_r;

    if (set_s) begin
      set_mask_s = idx_mask(issue_rd);
      // Re-reserving an already busy register does not change the count
      cnt_inc_s  = !busy_r[issue_rd];
    end else begin
      set_mask_s = BUSY_NONE;
      cnt_inc_s  = 1'b0;
    end

    if (clr_s) begin
      clr_mask_s = idx_mask(write_reg);
      // A clear that loses to a same-register set removes nothing
      cnt_dec_s  = busy_r[write_reg] && !(set_s && (issue_rd == write_reg));
    end else begin
      clr_mask_s = BUSY_NONE;
      cnt_dec_s  = 1'b0;
    end

    if (flush) begin
      busy_next_s  = BUSY_NONE;
      count_next_s = CNT_ZERO;
    end else begin
      // Clear first, then set, so a same-register set survives
      busy_next_s  = (busy_r & ~clr_mask_s) | set_mask_s;
      count_next_s = count_r + {{REG_IDX_W{1'b0}}, cnt_inc_s}
                             - {{REG_IDX_W{1'b0}}, cnt_dec_s};
    end
  end

  // Busy vector and counter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r  <= BUSY_NONE;
      count_r <= CNT_ZERO;
    end else begin
      busy_r  <= busy_next_s;
      count_r <= count_next_s;
    end
  end

  assign busy       = busy_r;
  assign busy_count = count_r;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 32 x 32-bit architectural integer register file with a
// RAW-hazard scoreboard.
//   clk, reset            - clock, asynchronous active-high reset
//   write_enable/_reg/_data - write-back port (x0 writes ignored)
//   issue_valid, issue_rd - destination reservation from decode
//   flush                 - drops all pending reservations
//   rs1_addr/rs2_addr     - read port indices
//   rs1_data/rs2_data     - combinational read data, x0 reads 0
//   hazard                - a source operand still has a pending write
//   busy_count            - number of reserved registers
// Optional feature (macro REGFILE_BYPASS_EN): a read of the register being
// written this cycle returns write_data immediately and is not reported as
// a hazard. Without the macro the value and the hazard release both show up
// the cycle after the write.
module reg_file_sb
  import reg_file_sb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_enable,
  input  logic [REG_IDX_W-1:0] write_reg,
  input  logic [XLEN-1:0]      write_data,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 flush,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic                 hazard,
  output logic [REG_IDX_W:0]   busy_count
);

  xlen_t     regs_r [NREGS];
  busy_vec_t busy_s;
  logic      byp1_s;
  logic      byp2_s;
  xlen_t     rs1_val_s;
  xlen_t     rs2_val_s;
  logic      haz1_s;
  logic      haz2_s;

  reg_scoreboard u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .flush        (flush),
    .busy         (busy_s),
    .busy_count   (busy_count)
  );

  // Register array; x0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= XLEN_ZERO;
      end
    end else if (write_enable && (write_reg != REG_X0)) begin
      regs_r[write_reg] <= write_data;
    end
  end

  // Bypass hit detection; held off during reset so outputs read zero
  always_comb begin
    byp1_s = 1'b0;
    byp2_s = 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (write_enable && !reset && (write_reg != REG_X0)) begin
      byp1_s = (write_reg == rs1_addr);
      byp2_s = (write_reg == rs2_addr);
    end else begin
      byp1_s = 1'b0;
      byp2_s = 1'b0;
    end
`else
    byp1_s = 1'b0;
    byp2_s = 1'b0;
`endif
  end

  // Read muxing and per-port hazard
  always_comb begin
    rs1_val_s = XLEN_ZERO;
    rs2_val_s = XLEN_ZERO;

    if (rs1_addr == REG_X0) begin
      rs1_val_s = XLEN_ZERO;
    end else if (byp1_s) begin
      rs1_val_s = write_data;
    end else begin
      rs1_val_s = regs_r[rs1_addr];
    end

    if (rs2_addr == REG_X0) begin
      rs2_val_s = XLEN_ZERO;
    end else if (byp2_s) begin
      rs2_val_s = write_data;
    end else begin
      rs2_val_s = regs_r[rs2_addr];
    end

    // A bypassed operand is satisfied now, even if the register is being
    // re-reserved this same cycle for a younger instruction.
    haz1_s = busy_s[rs1_addr] && (rs1_addr != REG_X0) && !byp1_s;
    haz2_s = busy_s[rs2_addr] && (rs2_addr != REG_X0) && !byp2_s;
  end

  assign rs1_data = rs1_val_s;
  assign rs2_data = rs2_val_s;
  assign hazard   = haz1_s || haz2_s;

endmodule
